spi_master: RTL
===============

# spi_master

SPI initiator that drives the team's byte-wide SPI slave. It accepts a one-cycle start request carrying an opcode and a data byte. It then generates the chip-select, SCK, opcode and MOSI sequence the slave expects, MSB first, and returns the byte read back on MISO. It sits between the system-side controller and the SRAM/SPI slave port.

## Interface
- CLK_DIV, 2: clk cycles per SCK half-period; legal range is 1 or more.
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  transaction request; sampled only in IDLE.
- opcode  in  2  2'b10 is a write (send tx_data); 2'b11 is a read (capture MISO). Any other value is ignored.
- tx_data  in  8  byte to shift out on writes.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse when a transaction completes.
- rx_data  out  8  last byte read; updated only by read transactions.
- cs  out  1  active-low chip select to the slave.
- sck  out  1  SPI clock; idles low.
- mosi  out  1  serial data to the slave.
- op  out  3  opcode to the slave: 3'b000 idle, 3'b010 write, 3'b011 read.
- miso  in  1  serial data from the slave.

## Operation
- Reset (rst=0, asynchronous) forces: cs=1, sck=0, mosi=0, op=000, busy=0, done=0, rx_data=8'h00, state IDLE, all counters 0. A reset mid-transaction aborts it immediately; no done pulse is produced.
- States: IDLE, SETUP, OPCODE, SHIFT, HOLD.
- IDLE: cs=1, sck=0, op=000. If start=1 and opcode[1]=1:
  - latch opcode and tx_data;
  - go to SETUP with busy=1 and cs=0.
  - Otherwise stay in IDLE.
- SETUP (N = CLK_DIV cycles): cs=0, op=000, sck=0.
- OPCODE (N cycles): op = {1'b0, latched opcode}; sck=0; mosi = tx bit 7 on a write, 0 on a read.
- SHIFT (16N cycles): 8 bits, k = 7 down to 0. For each bit:
  - low phase, N cycles: sck=0, mosi = tx bit k on a write, 0 on a read;
  - high phase, N cycles: sck=1, mosi held;
  - at the clk edge that ends the high phase, miso is shifted into the rx shift register (LSB in, MSB first).
- HOLD (N cycles): sck=0, op=000, cs=0, mosi=0.
- On leaving HOLD, the registered outputs change as follows:
  - go to IDLE with cs=1, busy=0, done=1 for exactly one cycle;
  - on a read, rx_data loads the shift register in the same cycle;
  - on a write, rx_data is unchanged.
- start while busy=1 is ignored; opcode and tx_data changes during a transaction have no effect.
- The bit counter wraps after bit 0 and never produces a ninth SCK pulse.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Acceptance edge T0 is the rising clk edge where start=1 is sampled in IDLE.
- Sequence relative to T0:
  - busy=1 and cs=0 from T0;
  - op goes nonzero at T0+N;
  - first sck rise at T0+3N;
  - last sck fall at T0+18N;
  - busy=0, cs=1 and done=1 at T0+19N.
- Exactly 8 sck rising edges per transaction. mosi is stable at least N cycles before every sck rise and through its high phase.
- The slave samples MOSI on sck rise and must present MISO before the end of the high phase.
- start sampled in the done=1 cycle is accepted (state is already IDLE): back-to-back transactions have cs high for one cycle.

## Test plan
- Write, CLK_DIV=2, opcode=10, tx_data=8'hAA. Required:
  - mosi at each sck rise reads 1,0,1,0,1,0,1,0;
  - op goes 000, then 010, then 000;
  - busy high exactly 38 cycles; one done pulse; rx_data stays 8'h00.
- Read, opcode=11, slave model drives 8'h55 MSB first on miso. Required: rx_data=8'h55 at done, op=011 during SHIFT, mosi=0 throughout.
- Write 8'hFF, then write 8'h00, with start held high through the first done cycle. Required:
  - second transaction begins at the done edge;
  - cs high exactly 1 cycle between the two;
  - mosi all ones, then all zeros.
- start with opcode=00, and separately with opcode=01. Required: no state change; cs stays 1, busy stays 0, no done.
- Read 8'hC3 in progress, pulse start=1 with opcode=10 mid-SHIFT. Required: pulse ignored, 8 sck pulses total, rx_data=8'hC3.
- Assert rst=0 during the 4th SHIFT bit. Required:
  - immediately cs=1, sck=0, op=000, busy=0, rx_data=00, and no done;
  - after release, a read of 8'h3C completes correctly.

Source files
------------

// File: rtl/spi_master.sv
// spi_master
// SPI initiator for the byte-wide SPI slave. A one-cycle start request in IDLE
// launches a transaction. The block drives chip select low, presents the opcode,
// shifts eight bits MSB first on mosi (writes) and captures eight bits on miso
// (reads), then returns to IDLE with a one-cycle done pulse.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   start    transaction request, sampled only in IDLE
//   opcode   2'b10 write, 2'b11 read, anything else ignored
//   tx_data  byte shifted out on writes
//   miso     serial data from the slave
//   busy     high while a transaction is in progress
//   done     one-cycle completion pulse
//   rx_data  last byte read (updated by reads only)
//   cs       active-low chip select
//   sck      SPI clock, idles low
//   mosi     serial data to the slave
//   op       opcode to the slave: 000 idle, 010 write, 011 read
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | cs high, waiting for start with opcode[1]=1
// SETUP  | cs low, CLK_DIV cycles before the opcode appears
// OPCODE | op presented, first mosi bit set up, CLK_DIV cycles
// SHIFT  | 8 bits, each CLK_DIV cycles sck low then CLK_DIV cycles sck high
// HOLD   | sck low, op idle, CLK_DIV cycles before cs is released
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic [7:0] tx_data,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       cs,
  output logic       sck,
  output logic       mosi,
  output logic [2:0] op
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_OPCODE = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            high_q, high_d;
  logic            rd_q, rd_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      sh_q, sh_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      rx_q, rx_d;
  logic            cs_q, cs_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic [2:0]      op_q, op_d;

  logic            tc;
  logic [2:0]      bit_dec;

  // Down-counter reaching zero marks the last cycle of the current phase.
  assign tc      = (cnt_q == '0);
  assign bit_dec = bit_q - 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    high_d  = high_q;
    rd_d    = rd_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rx_d    = rx_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    op_d    = op_q;

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        op_d   = 3'b000;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start && opcode[1]) begin
          rd_d    = opcode[0];
          tx_d    = tx_data;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tc) begin
          op_d    = {2'b01, rd_q};
          mosi_d  = rd_q ? 1'b0 : tx_q[7];
          cnt_d   = CNT_LOAD;
          state_d = ST_OPCODE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_OPCODE: begin
        // mosi already carries bit 7, which doubles as the first low phase data.
        if (tc) begin
          bit_d   = 3'd7;
          high_d  = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_SHIFT: begin
        if (tc) begin
          cnt_d = CNT_LOAD;
          if (!high_q) begin
            high_d = 1'b1;
            sck_d  = 1'b1;
          end else begin
            sck_d  = 1'b0;
            high_d = 1'b0;
            sh_d   = {sh_q[6:0], miso};
            // Bit 0 leaves SHIFT, so the counter never wraps into a ninth pulse.
            if (bit_q == 3'd0) begin
              op_d    = 3'b000;
              mosi_d  = 1'b0;
              state_d = ST_HOLD;
            end else begin
              bit_d  = bit_dec;
              mosi_d = rd_q ? 1'b0 : tx_q[bit_dec];
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_HOLD: begin
        if (tc) begin
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rd_q) begin
            rx_d = sh_q;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        op_d    = 3'b000;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      high_q  <= 1'b0;
      rd_q    <= 1'b0;
      tx_q    <= 8'h00;
      sh_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= 8'h00;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      high_q  <= high_d;
      rd_q    <= rd_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      op_q    <= op_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign cs      = cs_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign op      = op_q;

endmodule
